egress_port_queue: RTL

Per-port egress buffer placed directly downstream of one crossbar output: it absorbs that output's (out_wrN, out_ctlN, out_dataN) word stream into a FIFO. It drains the FIFO toward the 100G MAC/stat path through a valid/ready interface, paced to at most one word every RATE_DIV cycles. It also measures backlog: it reports current occupancy, a high-water mark and a drop counter. Six instances, one per egress port, sit between the crossbar and the port MACs.

---
 rtl/egress_pkg.sv | 28 ++
 rtl/egress_fifo_mem.sv | 45 ++++
 rtl/egress_port_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/egress_pkg.sv
// ----------------------------------------------------------------------------
// egress_pkg
// Definitions shared by the egress port queue:
//   - pace_state_t : states of the output pacing FSM
//   - depth_of()   : FIFO depth in words for a given address width
//   - sat_inc()    : increment that stops at the all-ones value of a counter
// ----------------------------------------------------------------------------
package egress_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // queue empty, nothing presented
      SEND = 2'd1,   // head word presented, out_valid high
      GAP  = 2'd2    // spacing interval between two words
   } pace_state_t;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Counters up to 64 bits wide; 'width' is the real counter width, so the
   // counter sticks at its own all-ones value instead of wrapping.
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
      logic [63:0] max_val;
      max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (value == max_val) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/egress_fifo_mem.sv
// ----------------------------------------------------------------------------
// egress_fifo_mem
// Register-array storage for the egress queue. Each entry holds one
// {ctl, data} pair so the two fields can never drift apart.
//   clk      : rising-edge clock
//   wr_en    : write the pair at wr_addr this cycle
//   wr_addr  : write index
//   wr_ctl   : control word to store
//   wr_data  : data word to store
//   rd_addr  : read index (asynchronous, show-ahead)
//   rd_ctl   : control word at rd_addr
//   rd_data  : data word at rd_addr
// ----------------------------------------------------------------------------
module egress_fifo_mem
   import egress_pkg::*;
#(
   parameter int DATA_WIDTH = 480,
   parameter int CTRL_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [CTRL_WIDTH-1:0] wr_ctl,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [CTRL_WIDTH-1:0] rd_ctl,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; the pointers alone decide which entries are
   // meaningful, and leaving the array unreset keeps it a plain register file.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= {wr_ctl, wr_data};
      end
   end

   assign {rd_ctl, rd_data} = mem[rd_addr];

endmodule

// File: rtl/egress_port_queue.sv
// ----------------------------------------------------------------------------
// egress_port_queue
// Per-port egress buffer behind one crossbar output. Incoming words are
// queued in a 2**ADDR_WIDTH entry FIFO and drained through a valid/ready
// interface, at most one word every RATE_DIV cycles. Backlog statistics are
// kept alongside.
//   clk           : rising-edge clock
//   rst           : asynchronous reset, active low
//   in_wr         : input word valid (no upstream backpressure)
//   in_ctl        : input control word
//   in_data       : input data word
//   out_valid     : head word presented
//   out_ready     : downstream takes the head word
//   out_ctl       : head control word (0 when out_valid is low)
//   out_data      : head data word (0 when out_valid is low)
//   occupancy     : words currently stored, 0..DEPTH
//   max_occupancy : high-water mark since reset or clr_stats
//   drop_count    : words discarded because the queue was full (saturating)
//   clr_stats     : synchronous clear of max_occupancy and drop_count
// ----------------------------------------------------------------------------
module egress_port_queue
   import egress_pkg::*;
#(
   parameter int DATA_WIDTH = 480,
   parameter int CTRL_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int RATE_DIV   = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_wr,
   input  logic [CTRL_WIDTH-1:0] in_ctl,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_WIDTH-1:0] out_ctl,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic [ADDR_WIDTH:0]   max_occupancy,
   output logic [CNT_WIDTH-1:0]  drop_count,
   input  logic                  clr_stats
);

   localparam int                DEPTH   = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
   localparam int                PACE_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(RATE_DIV - 1);

   // Pointers carry one extra wrap bit, so their difference is the fill level
   // and distinguishes full from empty without a separate counter.
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic [ADDR_WIDTH:0] occ_next;
   logic                full;
   logic                pop;
   logic                push_ok;
   logic                drop;

   pace_state_t         state;
   pace_state_t         state_next;
   logic [PACE_W-1:0]   pace_cnt;
   logic [PACE_W-1:0]   pace_next;

   logic [CTRL_WIDTH-1:0] head_ctl;
   logic [DATA_WIDTH-1:0] head_data;

   assign occupancy = wr_ptr - rd_ptr;
   assign full      = (occupancy == DEPTH_W);
   assign out_valid = (state == SEND);
   assign pop       = out_valid & out_ready;
   // A full queue still accepts a word when the head leaves in the same cycle.
   assign push_ok   = in_wr & (~full | pop);
   assign drop      = in_wr & full & ~pop;
   assign occ_next  = occupancy + (push_ok ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);

   egress_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_ctl  (in_ctl),
      .wr_data (in_data),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_ctl  (head_ctl),
      .rd_data (head_data)
   );

   // Gating with out_valid keeps the outputs at 0 out of reset and while idle,
   // since the storage itself is never cleared.
   assign out_ctl  = out_valid ? head_ctl  : '0;
   assign out_data = out_valid ? head_data : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Statistics. A clear restarts the high-water mark from the level the
   // queue is about to hold, and a drop in the clear cycle is still counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_occupancy <= '0;
         drop_count    <= '0;
      end else if (clr_stats) begin
         max_occupancy <= occ_next;
         drop_count    <= drop ? CNT_WIDTH'(1) : '0;
      end else begin
         if (occ_next > max_occupancy) max_occupancy <= occ_next;
         if (drop) drop_count <= CNT_WIDTH'(sat_inc(64'(drop_count), CNT_WIDTH));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pace_cnt <= '0;
      end else begin
         state    <= state_next;
         pace_cnt <= pace_next;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      pace_next  = pace_cnt;
      case (state)
         IDLE: begin
            // The counter keeps running while idle so a gap that began before
            // the queue emptied is still honoured.
            if (pace_cnt != '0) pace_next = pace_cnt - PACE_W'(1);
            if (occ_next != '0) state_next = (pace_cnt == '0) ? SEND : GAP;
         end
         SEND: begin
            if (pop) begin
               if (RATE_DIV == 1) begin
                  state_next = (occ_next != '0) ? SEND : IDLE;
               end else begin
                  pace_next  = PACE_LOAD;
                  state_next = GAP;
               end
            end
         end
         GAP: begin
            // Leave on the cycle the counter reaches zero, so words are
            // spaced exactly RATE_DIV cycles apart.
            if (pace_cnt != '0) pace_next = pace_cnt - PACE_W'(1);
            if (pace_next == '0) state_next = (occ_next != '0) ? SEND : IDLE;
         end
         default: begin
            state_next = IDLE;
            pace_next  = '0;
         end
      endcase
   end

endmodule
